// File: rtl/megapacket_arbiter_if.sv
// megapacket_arbiter_if: the two upstream streams and the merged downstream stream of the arbiter
interface megapacket_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s0_tdata;
  logic              s0_tvalid;
  logic              s0_tlast;
  logic              s0_tready;
  logic [DATA_W-1:0] s1_tdata;
  logic              s1_tvalid;
  logic              s1_tlast;
  logic              s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tdest;
  logic              m_tready;
  modport slave (
    input  s0_tdata, s0_tvalid, s0_tlast,
    input  s1_tdata, s1_tvalid, s1_tlast,
    input  m_tready,
    output s0_tready, s1_tready,
    output m_tdata, m_tvalid, m_tlast, m_tdest
  );
  modport master (
    output s0_tdata, s0_tvalid, s0_tlast,
    output s1_tdata, s1_tvalid, s1_tlast,
    output m_tready,
    input  s0_tready, s1_tready,
    input  m_tdata, m_tvalid, m_tlast, m_tdest
  );
endinterface

// File: rtl/megapacket_arbiter.sv
// megapacket_arbiter: packet-granular round-robin merge of two AXI-Stream channels with a length cap
module megapacket_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                aclk,
  input  logic                rst,
  input  logic                enable,
  input  logic [15:0]         max_beats,
  megapacket_arbiter_if.slave bus,
  output logic [CNT_W-1:0]    pkt_count0,
  output logic [CNT_W-1:0]    pkt_count1,
  output logic                err_overlen
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t            r_state;
  logic              r_g;
  logic              r_last_grant;
  logic [15:0]       r_beat_cnt;
  logic [15:0]       r_max;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic              r_tlast;
  logic              r_tdest;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;
  logic              r_err;
  logic              w_load;
  logic              w_rdy;
  logic              w_sv;
  logic              w_sl;
  logic [DATA_W-1:0] w_sd;
  logic              w_force;
  logic              w_acc;
  logic              w_end;
  assign w_load  = !r_tvalid || bus.m_tready;
  assign w_sv    = r_g ? bus.s1_tvalid : bus.s0_tvalid;
  assign w_sl    = r_g ? bus.s1_tlast : bus.s0_tlast;
  assign w_sd    = r_g ? bus.s1_tdata : bus.s0_tdata;
  // tready is gated by rst so nothing is accepted while reset is held
  assign w_rdy   = rst && r_state == BUSY && w_load;
  assign w_acc   = w_sv && w_rdy;
  assign w_force = r_max != 16'd0 && r_beat_cnt == r_max - 16'd1;
  assign w_end   = w_acc && (w_sl || w_force);
  assign bus.s0_tready = w_rdy && !r_g;
  assign bus.s1_tready = w_rdy && r_g;
  assign bus.m_tdata   = r_tdata;
  assign bus.m_tvalid  = r_tvalid;
  assign bus.m_tlast   = r_tlast;
  assign bus.m_tdest   = r_tdest;
  assign pkt_count0    = r_cnt0;
  assign pkt_count1    = r_cnt1;
  assign err_overlen   = r_err;
  always_ff @(posedge aclk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_g          <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat_cnt   <= 16'd0;
      r_max        <= max_beats;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdest      <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_load) begin
        r_tvalid <= w_acc;
        if (w_acc) begin
          r_tdata <= w_sd;
          r_tlast <= w_sl || w_force;
          r_tdest <= r_g;
        end
      end
      if (r_state == IDLE) begin
        if (enable && (bus.s0_tvalid || bus.s1_tvalid)) begin
          r_state <= BUSY;
          r_g     <= bus.s1_tvalid && (!bus.s0_tvalid || !r_last_grant);
        end
      end else if (w_acc) begin
        r_beat_cnt <= w_end ? 16'd0 : r_beat_cnt + 16'd1;
        if (w_end) begin
          r_state      <= IDLE;
          r_last_grant <= r_g;
          if (r_g) r_cnt1 <= r_cnt1 + CNT_W'(1);
          else r_cnt0 <= r_cnt0 + CNT_W'(1);
          if (w_force && !w_sl) r_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_megapacket_arbiter.sv
// tb_megapacket_arbiter: scoreboard bench; expected beats derived from packet lengths and the length cap
module tb_megapacket_arbiter;
  logic        aclk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] max_beats = 16'd0;
  logic [31:0] pkt_count0;
  logic [31:0] pkt_count1;
  logic        err_overlen;
  megapacket_arbiter_if #(.DATA_W(32)) bus();
  megapacket_arbiter #(.DATA_W(32), .CNT_W(32)) dut (
    .aclk(aclk), .rst(rst), .enable(enable), .max_beats(max_beats), .bus(bus),
    .pkt_count0(pkt_count0), .pkt_count1(pkt_count1), .err_overlen(err_overlen)
  );
  always #5 aclk = ~aclk;
  int total = 0;
  int bad = 0;
  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  int order[$];
  int exp_cnt[2];
  bit exp_err;
  int cur_max;
  int rmode = 0;
  bit mon_en = 1'b1;
  bit gap_chk = 1'b0;
  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bus.m_tready = rmode == 0 ? 1'b1 : rmode == 1 ? ~bus.m_tready : 1'($urandom_range(0, 1));
    end
  end
  logic [31:0] prev_d;
  logic        prev_l;
  logic        prev_dst;
  bit          prev_stall = 1'b0;
  bit          mid = 1'b0;
  bit          seen = 1'b0;
  int          idle_run = 0;
  logic [32:0] e;
  always @(negedge aclk) begin
    if (!rst) begin
      prev_stall = 1'b0;
      mid = 1'b0;
      seen = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(bus.m_tvalid), 64'd1);
        check("hold_beat", {bus.m_tdest, bus.m_tlast, bus.m_tdata}, {prev_dst, prev_l, prev_d});
      end
      if (bus.m_tvalid && !bus.m_tready) check("stall_tready", {bus.s0_tready, bus.s1_tready}, 64'd0);
      if (bus.m_tvalid && bus.m_tready && mon_en) begin
        if (!mid) begin
          order.push_back(int'(bus.m_tdest));
          if (gap_chk && seen) check("bubble", 64'(idle_run), 64'd1);
          seen = 1'b1;
        end
        mid = !bus.m_tlast;
        if (bus.m_tdest ? exp1.size() == 0 : exp0.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tdest=%0d data=%0h expected no beat", bus.m_tdest, bus.m_tdata);
        end else begin
          if (bus.m_tdest) e = exp1.pop_front();
          else e = exp0.pop_front();
          check("beat", {bus.m_tlast, bus.m_tdata}, e);
        end
      end
      idle_run = bus.m_tvalid ? 0 : idle_run + 1;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_d = bus.m_tdata;
      prev_l = bus.m_tlast;
      prev_dst = bus.m_tdest;
    end
  end
  task automatic set_ch(int ch, logic v, logic [31:0] d, logic l);
    if (ch == 0) begin
      bus.s0_tvalid = v; bus.s0_tdata = d; bus.s0_tlast = l;
    end else begin
      bus.s1_tvalid = v; bus.s1_tdata = d; bus.s1_tlast = l;
    end
  endtask
  task automatic drive_beat(int ch, logic [31:0] d, logic l, int gap);
    int t;
    t = 0;
    if (gap > 0) begin
      repeat (gap) @(posedge aclk);
      #1;
    end
    set_ch(ch, 1'b1, d, l);
    @(negedge aclk);
    while (!(ch == 0 ? bus.s0_tready : bus.s1_tready) && t < 2000) begin
      @(negedge aclk);
      t++;
    end
    if (t >= 2000) begin
      total++;
      bad++;
      $display("FAIL timeout: ch%0d beat %0h got no tready expected within 2000 cycles", ch, d);
    end
    @(posedge aclk);
    #1;
    set_ch(ch, 1'b0, 32'd0, 1'b0);
  endtask
  task automatic send_pkt(int ch, int len, logic [31:0] base, bit gaps, int drop_at);
    for (int i = 0; i < len; i++) begin
      logic l, f;
      l = i == len - 1;
      f = cur_max != 0 && (i + 1) % cur_max == 0;
      if (ch == 0) exp0.push_back({l || f, base + 32'(i)});
      else exp1.push_back({l || f, base + 32'(i)});
      if (l || f) exp_cnt[ch]++;
      if (f && !l) exp_err = 1'b1;
      drive_beat(ch, base + 32'(i), l, gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == drop_at) enable = 1'b0;
    end
  endtask
  task automatic do_reset(int m);
    rst = 1'b0;
    max_beats = 16'(m);
    cur_max = m;
    set_ch(0, 1'b0, 32'd0, 1'b0);
    set_ch(1, 1'b0, 32'd0, 1'b0);
    @(posedge aclk);
    #1;
    check("rst_out", {bus.m_tvalid, bus.m_tlast, bus.m_tdest, bus.m_tdata}, 64'd0);
    check("rst_tready", {bus.s0_tready, bus.s1_tready}, 64'd0);
    check("rst_cnt", {pkt_count0, pkt_count1}, 64'd0);
    check("rst_err", 64'(err_overlen), 64'd0);
    @(posedge aclk);
    #1;
    rst = 1'b1;
    max_beats = 16'($urandom);
    exp0.delete();
    exp1.delete();
    order.delete();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    exp_err = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    check("drain", 64'(exp0.size() + exp1.size()), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask
  task automatic check_regs();
    check("pkt_count0", 64'(pkt_count0), 64'(exp_cnt[0]));
    check("pkt_count1", 64'(pkt_count1), 64'(exp_cnt[1]));
    check("err_overlen", 64'(err_overlen), 64'(exp_err));
  endtask
  initial begin
    int maxes[4];
    maxes = '{1, 3, 0, 5};
    do_reset(0);
    fork
      send_pkt(0, 4, 32'hA0, 1'b0, -1);
      begin
        @(negedge aclk);
        check("t1_tready_idle", 64'(bus.s0_tready), 64'd0);
        @(negedge aclk);
        check("t1_tready_grant", 64'(bus.s0_tready), 64'd1);
        @(posedge aclk);
        #1;
        check("t1_first_out", {bus.m_tvalid, bus.m_tdata}, {1'b1, 32'hA0});
      end
    join
    drain();
    check_regs();
    do_reset(0);
    gap_chk = 1'b1;
    fork
      for (int i = 0; i < 4; i++) send_pkt(0, 3, 32'h100 + 32'(i * 16), 1'b0, -1);
      for (int i = 0; i < 4; i++) send_pkt(1, 3, 32'h200 + 32'(i * 16), 1'b0, -1);
    join
    drain();
    gap_chk = 1'b0;
    check_regs();
    check("rr_npkts", 64'(order.size()), 64'd8);
    foreach (order[i]) check("rr_order", 64'(order[i]), 64'(i % 2));
    rmode = 1;
    send_pkt(1, 8, 32'h300, 1'b0, -1);
    drain();
    rmode = 0;
    check_regs();
    do_reset(4);
    send_pkt(0, 4, 32'h400, 1'b0, -1);
    drain();
    check_regs();
    send_pkt(1, 6, 32'h410, 1'b0, -1);
    drain();
    check_regs();
    do_reset(0);
    fork
      send_pkt(0, 5, 32'h500, 1'b0, 1);
      send_pkt(1, 3, 32'h510, 1'b0, -1);
      begin
        int t;
        t = 0;
        while (pkt_count0 != 32'd1 && t < 200) begin
          @(negedge aclk);
          t++;
        end
        check("t5_ch0_done", 64'(pkt_count0), 64'd1);
        repeat (2) @(negedge aclk);
        repeat (4) begin
          @(negedge aclk);
          check("t5_no_grant", {bus.s1_tready, bus.m_tvalid}, 64'd0);
        end
        @(posedge aclk);
        #1;
        enable = 1'b1;
        @(negedge aclk);
        check("t5_decide", 64'(bus.s1_tready), 64'd0);
        @(negedge aclk);
        check("t5_grant", 64'(bus.s1_tready), 64'd1);
      end
    join
    drain();
    check_regs();
    check("t5_order", {32'(order[0]), 32'(order[1])}, {32'd0, 32'd1});
    mon_en = 1'b0;
    drive_beat(0, 32'h600, 1'b0, 0);
    drive_beat(0, 32'h601, 1'b0, 0);
    set_ch(0, 1'b1, 32'h602, 1'b0);
    do_reset(0);
    mon_en = 1'b1;
    fork
      send_pkt(1, 2, 32'h610, 1'b0, -1);
      send_pkt(0, 2, 32'h620, 1'b0, -1);
    join
    drain();
    check_regs();
    check("t6_first", 64'(order[0]), 64'd0);
    foreach (maxes[k]) begin
      do_reset(maxes[k]);
      rmode = 2;
      fork
        for (int i = 0; i < 5; i++) send_pkt(0, int'($urandom_range(1, 9)), 32'h1000 * 32'(k + 1) + 32'(i * 16), 1'b1, -1);
        for (int i = 0; i < 5; i++) send_pkt(1, int'($urandom_range(1, 9)), 32'h8000 * 32'(k + 1) + 32'(i * 16), 1'b1, -1);
      join
      drain();
      rmode = 0;
      check_regs();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/megapacket_arbiter.md
Name: megapacket_arbiter

Overview:
Shares one 32-bit AXI-Stream DMA path between two upstream packet-merging streams (channel 0 and channel 1).
- Grants the output one whole packet at a time, round-robin.
- Tags each beat with its source channel on m_tdest.
- Enforces a runtime maximum packet length by forcing tlast.
- Keeps per-channel packet counters and a sticky over-length flag for the PS.
- Sits between the packet-merging stages and the DMA S2MM input.

Parameters:
DATA_W, 32, tdata width of all streams
CNT_W, 32, width of each per-channel packet counter

Ports:
aclk  input  1  clock
rst  input  1  reset; synchronous, active-low; clock aclk
enable  input  1  1 = new grants allowed; 0 = finish current packet, then hold idle
max_beats  input  16  max beats per output packet; 0 = unlimited; sampled only while rst=0
s0_tdata  input  DATA_W  channel 0 data
s0_tvalid  input  1  channel 0 valid
s0_tlast  input  1  channel 0 end of packet
s0_tready  output  1  channel 0 ready
s1_tdata  input  DATA_W  channel 1 data
s1_tvalid  input  1  channel 1 valid
s1_tlast  input  1  channel 1 end of packet
s1_tready  output  1  channel 1 ready
m_tdata  output  DATA_W  output data
m_tvalid  output  1  output valid
m_tlast  output  1  output end of packet (input tlast or forced)
m_tdest  output  1  source channel of current beat
m_tready  input  1  downstream ready
pkt_count0  output  CNT_W  output packets completed from channel 0
pkt_count1  output  CNT_W  output packets completed from channel 1
err_overlen  output  1  sticky: a packet was truncated by max_beats

Behaviour:
Reset
- On any aclk edge with rst=0:
  - state=IDLE, last_grant=1 (so channel 0 wins first), beat_cnt=0.
  - m_tvalid=0, m_tdata=0, m_tlast=0, m_tdest=0.
  - pkt_count0/1=0, err_overlen=0.
  - max_beats latched into max_reg.
- s0_tready and s1_tready are 0 during reset.
- Reset mid-packet abandons the packet; the output register is cleared, so no partial beat is presented.

State machine: IDLE, BUSY; grant register g
- IDLE -> BUSY when enable=1 and any sX_tvalid=1.
  - Only one channel valid: g = that channel.
  - Both valid: g = !last_grant.
- The decision takes one cycle. No s_tready is asserted in IDLE.
- BUSY -> IDLE on the cycle the last beat of the packet is accepted. At that transition: last_grant <= g, beat_cnt <= 0.
- The last beat is either input tlast or the forced-tlast beat.
- Result: one bubble cycle minimum between packets.
- enable is checked only in IDLE. Dropping it in BUSY never truncates a packet.

Handshake / output register (single full-throughput register slice)
- load = !m_tvalid || m_tready.
- sg_tready = (state==BUSY) && load. The other channel's tready is 0.
- Accepted beat (sg_tvalid && sg_tready): next cycle m_tdata = data, m_tdest = g, m_tvalid = 1.
- m_tlast = sg_tlast OR (max_reg!=0 && beat_cnt == max_reg-1).
- Latency: 1 cycle from input acceptance to m_tvalid.
- If load=1 and no beat is accepted, m_tvalid <= 0.
- Output holds stable while m_tvalid && !m_tready (AXIS compliant).
- No beat is dropped or duplicated under any m_tready pattern.
- Streaming throughput is 1 beat/cycle inside a packet.

Counting / arithmetic
- beat_cnt is 16-bit. It increments per accepted beat and resets to 0 on packet end.
- Forced tlast: the beat at index max_reg-1 is the output's last beat, and err_overlen <= 1.
  - The channel's remaining beats are arbitrated as a new packet.
  - If input tlast coincides with the forced beat, it is a normal end with no error.
- pkt_countG increments when the last beat of a packet is accepted on the input side. It wraps modulo 2^CNT_W.
- max_beats=1: every beat is its own packet.
  - err_overlen sets on any beat whose input tlast=0.
- Changing max_beats outside reset has no effect.

Test Plan:
1. After reset, ch0 sends 4 beats 0xA0..0xA3 (tlast on 0xA3), m_tready=1 -> s0_tready rises 1 cycle after s0_tvalid; m_tvalid 1 cycle after first acceptance; output 0xA0..0xA3 with tlast only on 0xA3; tdest=0; pkt_count0=1.
2. ch0 and ch1 both continuously valid, 3-beat packets, max_beats=0 -> output channel order 0,1,0,1,...; one idle cycle between packets; pkt_count0 and pkt_count1 both equal 4 after 8 packets.
3. One 8-beat ch1 packet, m_tready pattern 1,0,1,0,... -> output sequence exactly equal to input; data stable during each m_tready=0; s1_tready low whenever m_tvalid=1 and m_tready=0.
4. max_beats=4 latched at reset; ch1 sends a 6-beat packet -> output tlast on beat 4, err_overlen=1, beats 5-6 form a second packet with tlast on beat 6, pkt_count1=2.
5. enable=0 asserted during beat 2 of a 5-beat ch0 packet, ch1 valid -> ch0 packet completes; no grant while enable=0; ch1 is granted 1 cycle after enable returns to 1.
6. rst=0 during beat 3 of a packet -> next edge m_tvalid=0, both tready=0, counters=0, err_overlen=0; after release, ch0 wins the first arbitration.
